// File: rtl/pb_uart_regs_v2_if.sv
// pb_uart_regs_v2_if
//   PicoBlaze port bus as seen by a port-mapped peripheral.
//   port_id      : port address driven by the processor
//   data_in      : write data driven by the processor
//   data_out     : registered read data returned by the peripheral
//   read_strobe  : processor read strobe
//   write_strobe : processor write strobe
//   interrupt    : level interrupt request returned by the peripheral
//   master modport = processor side, slave modport = peripheral side.
interface pb_uart_regs_v2_if;
  logic [7:0] port_id;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read_strobe;
  logic       write_strobe;
  logic       interrupt;

  modport master (
    output port_id, data_in, read_strobe, write_strobe,
    input  data_out, interrupt
  );

  modport slave (
    input  port_id, data_in, read_strobe, write_strobe,
    output data_out, interrupt
  );
endinterface

// File: rtl/pb_uart_regs_v2.sv
// pb_uart_regs_v2
//   PicoBlaze port-mapped register file for the UART (second generation).
//   Sits between the PicoBlaze port bus and the UART TX/RX FIFOs plus the
//   baud generator.
// Ports
//   clk, reset          : system clock, asynchronous active-low reset
//   bus (slave)         : port_id, data_in, data_out (registered),
//                         read_strobe, write_strobe, interrupt (registered)
//   buffer_write        : TX FIFO push pulse, data on uart_data_write
//   buffer_read         : RX FIFO pop pulse, head on uart_data_read
//   rx_*/tx_* flags     : FIFO status inputs
//   enable              : CONTROL[0]
//   uart_clock_divide   : active baud divider (DIV_WIDTH bits)
// Register offsets from BASE_ADDRESS
//   0 DATA, 1 CONTROL, 2 STATUS, 3 IRQ_MASK, 4 IRQ_PEND (W1C, bit 7 clears
//   tx_drop), 5..4+DIV_BYTES divider bytes (LE), 5+DIV_BYTES TIMEOUT.
module pb_uart_regs_v2 #(
  parameter logic [7:0]           BASE_ADDRESS = 8'h00,
  parameter int unsigned          DIV_WIDTH    = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET    = '0,
  parameter int unsigned          TO_SHIFT     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pb_uart_regs_v2_if.slave     bus,
  output logic                 buffer_write,
  output logic [7:0]           uart_data_write,
  output logic                 buffer_read,
  input  logic [7:0]           uart_data_read,
  input  logic                 rx_data_present,
  input  logic                 rx_half_full,
  input  logic                 rx_full,
  input  logic                 tx_data_present,
  input  logic                 tx_half_full,
  input  logic                 tx_full,
  output logic                 enable,
  output logic [DIV_WIDTH-1:0] uart_clock_divide
);

  localparam int unsigned DIV_BYTES = DIV_WIDTH / 8;
  localparam int unsigned CNT_W     = 8 + TO_SHIFT;

  localparam logic [7:0] OFF_DATA   = 8'd0;
  localparam logic [7:0] OFF_CTRL   = 8'd1;
  localparam logic [7:0] OFF_STAT   = 8'd2;
  localparam logic [7:0] OFF_MASK   = 8'd3;
  localparam logic [7:0] OFF_PEND   = 8'd4;
  localparam logic [7:0] OFF_DIVTOP = 8'(4 + DIV_BYTES);
  localparam logic [7:0] OFF_TO     = 8'(5 + DIV_BYTES);

  logic [7:0]           data_out_q, data_out_d;
  logic                 buffer_write_q, buffer_write_d;
  logic [7:0]           uart_data_write_q, uart_data_write_d;
  logic                 buffer_read_q, buffer_read_d;
  logic [7:0]           ctrl_q, ctrl_d;
  logic [4:0]           mask_q, mask_d;
  logic [4:0]           pend_q, pend_d;
  logic                 tx_drop_q, tx_drop_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
  logic [7:0]           timeout_q, timeout_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           flags_q, flags_d;
  logic                 irq_q, irq_d;

  logic [7:0]       off;
  logic             push, drop_set, pop;
  logic [4:0]       set_bits, clr_bits;
  logic [CNT_W-1:0] target;
  logic             to_clear, to_fire;
  logic [7:0]       rd_data;

  always_comb begin
    off      = bus.port_id - BASE_ADDRESS;
    push     = bus.write_strobe && (off == OFF_DATA) && !tx_full;
    drop_set = bus.write_strobe && (off == OFF_DATA) && tx_full;
    pop      = bus.read_strobe && (off == OFF_DATA) && rx_data_present;

    buffer_write_d    = push;
    uart_data_write_d = push ? bus.data_in : uart_data_write_q;
    buffer_read_d     = pop;

    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    timeout_d = timeout_q;
    shadow_d  = shadow_q;
    div_d     = div_q;
    tx_drop_d = tx_drop_q;

    if (bus.write_strobe) begin
      if (off == OFF_CTRL) ctrl_d    = bus.data_in;
      if (off == OFF_MASK) mask_d    = bus.data_in[4:0];
      if (off == OFF_TO)   timeout_d = bus.data_in;
      if ((off == OFF_PEND) && bus.data_in[7]) tx_drop_d = 1'b0;
      for (int unsigned k = 0; k < DIV_BYTES - 1; k++) begin
        if (off == 8'(5 + k)) shadow_d[8*k +: 8] = bus.data_in;
      end
      // Top-byte write commits the lower shadow bytes together with the new
      // top byte, so the baud generator never sees a half-updated divider.
      if (off == OFF_DIVTOP) begin
        div_d = shadow_q;
        div_d[DIV_WIDTH-8 +: 8] = bus.data_in;
      end
    end
    if (drop_set) tx_drop_d = 1'b1;

    // Idle timeout: counter saturates at the target so pend[4] fires once.
    target   = CNT_W'(timeout_q) << TO_SHIFT;
    to_clear = pop || !rx_data_present || (bus.write_strobe && (off == OFF_TO));
    to_fire  = 1'b0;
    cnt_d    = cnt_q;
    if (to_clear) begin
      cnt_d = '0;
    end else if (ctrl_q[0] && (timeout_q != 8'd0) && (cnt_q != target)) begin
      cnt_d   = cnt_q + CNT_W'(1);
      to_fire = (cnt_d == target);
    end

    flags_d     = {tx_data_present, rx_full, rx_half_full, rx_data_present};
    set_bits[0] = rx_data_present & ~flags_q[0];
    set_bits[1] = rx_half_full    & ~flags_q[1];
    set_bits[2] = rx_full         & ~flags_q[2];
    set_bits[3] = ~tx_data_present & flags_q[3];
    set_bits[4] = to_fire;
    clr_bits    = (bus.write_strobe && (off == OFF_PEND)) ? bus.data_in[4:0] : '0;
    pend_d      = (pend_q & ~clr_bits) | set_bits;
    irq_d       = |(pend_q & mask_q);

    rd_data = '0;
    if (off == OFF_DATA) rd_data = rx_data_present ? uart_data_read : 8'h00;
    if (off == OFF_CTRL) rd_data = ctrl_q;
    if (off == OFF_STAT) rd_data = {1'b0, tx_drop_q, tx_full, tx_half_full,
                                    tx_data_present, rx_full, rx_half_full,
                                    rx_data_present};
    if (off == OFF_MASK) rd_data = {3'b000, mask_q};
    if (off == OFF_PEND) rd_data = {3'b000, pend_q};
    if (off == OFF_TO)   rd_data = timeout_q;
    for (int unsigned k = 0; k < DIV_BYTES; k++) begin
      if (off == 8'(5 + k)) rd_data = div_q[8*k +: 8];
    end
    data_out_d = rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q        <= '0;
      buffer_write_q    <= 1'b0;
      uart_data_write_q <= '0;
      buffer_read_q     <= 1'b0;
      ctrl_q            <= '0;
      mask_q            <= '0;
      pend_q            <= '0;
      tx_drop_q         <= 1'b0;
      div_q             <= DIV_RESET;
      shadow_q          <= '0;
      timeout_q         <= '0;
      cnt_q             <= '0;
      flags_q           <= '0;
      irq_q             <= 1'b0;
    end else begin
      data_out_q        <= data_out_d;
      buffer_write_q    <= buffer_write_d;
      uart_data_write_q <= uart_data_write_d;
      buffer_read_q     <= buffer_read_d;
      ctrl_q            <= ctrl_d;
      mask_q            <= mask_d;
      pend_q            <= pend_d;
      tx_drop_q         <= tx_drop_d;
      div_q             <= div_d;
      shadow_q          <= shadow_d;
      timeout_q         <= timeout_d;
      cnt_q             <= cnt_d;
      flags_q           <= flags_d;
      irq_q             <= irq_d;
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.interrupt     = irq_q;
  assign buffer_write      = buffer_write_q;
  assign uart_data_write   = uart_data_write_q;
  assign buffer_read       = buffer_read_q;
  assign enable            = ctrl_q[0];
  assign uart_clock_divide = div_q;

endmodule
